// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared core constants for the integer register-file writeback path.
// Holds the default data and index widths, the register count, and the
// fixed slot numbers of the writeback sources on the arbiter request vector.
package regfile_wb_arbiter_pkg;

    localparam int CORE_XLEN       = 32;
    localparam int CORE_ADDR_WIDTH = 5;
    localparam int CORE_NUM_REGS   = 2 ** CORE_ADDR_WIDTH;

    // Writeback source slots on req_valid / req_addr / req_data.
    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_LSU = 1;
    localparam int WB_SRC_MDU = 2;
    localparam int NUM_WB_SRC = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin arbiter.
// The search for a grant starts at ptr_reg and wraps modulo N. The grant is
// combinational and is either one-hot or all-zero.
// After any grant, the pointer moves to the slot just past the winner.
// Every granted request is a transfer, because grant is only raised on a
// valid request.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset; clears the pointer and masks grants
//   req       per-requester request vector
//   grant     one-hot (or zero) grant, combinational
//   grant_idx binary index of the granted requester (valid when |grant)
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int PTR_W = $clog2(N);
    localparam logic [PTR_W:0] N_W = (PTR_W + 1)'(N);

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;

    // The sum is one bit wider than the pointer, so ptr+k cannot overflow.
    // The wrap is a compare-and-subtract because N need not be a power of two.
    always_comb begin
        logic [PTR_W:0] cand;
        logic           found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_reg} + (PTR_W + 1)'(k);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!found && req[cand[PTR_W-1:0]]) begin
                found                  = 1'b1;
                grant[cand[PTR_W-1:0]] = 1'b1;
                grant_idx              = cand[PTR_W-1:0];
            end
        end
        if (rst) begin
            grant = '0;
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (|grant) begin
            if ({1'b0, grant_idx} == N_W - 1'b1) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the integer register file.
// NUM_REQ writeback sources compete for the single write port through a
// valid/ready handshake. A round-robin arbiter grants one source per cycle.
// The winning write goes out one cycle later on a registered port.
// The block also keeps a busy scoreboard: issue sets a register's bit, and
// the commit edge of its write clears it.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   req_valid    per-source write request
//   req_addr     per-source destination, source i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data     per-source data, source i at [i*XLEN +: XLEN]
//   req_ready    per-source grant, one-hot or zero, combinational
//   issue_valid  decode issued an instruction that has a destination
//   issue_rd     destination of that instruction
//   rf_we        registered write enable to the register file
//   rf_addr_rd   registered write index to the register file
//   rf_data_rd   registered write data to the register file
//   busy         scoreboard; bit r set means register r has a pending producer
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN       = CORE_XLEN,
    parameter int ADDR_WIDTH = CORE_ADDR_WIDTH,
    parameter int NUM_REQ    = NUM_WB_SRC
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*XLEN-1:0]       req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          issue_valid,
    input  logic [ADDR_WIDTH-1:0]         issue_rd,
    output logic                          rf_we,
    output logic [ADDR_WIDTH-1:0]         rf_addr_rd,
    output logic [XLEN-1:0]               rf_data_rd,
    output logic [2**ADDR_WIDTH-1:0]      busy
);

    localparam int NREGS = 2 ** ADDR_WIDTH;
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [XLEN-1:0]       data_arr [NUM_REQ];
    logic [IDX_W-1:0]      grant_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [XLEN-1:0]       sel_data;

    logic                  rf_we_reg;
    logic [ADDR_WIDTH-1:0] rf_addr_reg;
    logic [XLEN-1:0]       rf_data_reg;
    logic [NREGS-1:0]      busy_reg;
    logic [NREGS-1:0]      busy_next;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign data_arr[gi] = req_data[gi*XLEN +: XLEN];
        end
    endgenerate

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .grant     (req_ready),
        .grant_idx (grant_idx)
    );

    assign sel_addr = addr_arr[grant_idx];
    assign sel_data = data_arr[grant_idx];

    // Scoreboard update. The clear comes first, so a same-cycle issue to the
    // same index wins: a new producer is now in flight. Bit 0 never sets.
    always_comb begin
        busy_next = busy_reg;
        if (rf_we_reg) begin
            busy_next[rf_addr_reg] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_reg   <= 1'b0;
            rf_addr_reg <= '0;
            rf_data_reg <= '0;
            busy_reg    <= '0;
        end else begin
            busy_reg <= busy_next;
            if (|req_ready) begin
                // An x0 write is granted and consumed, but it never reaches
                // the register file, so it cannot disturb the scoreboard.
                rf_we_reg   <= (sel_addr != '0);
                rf_addr_reg <= sel_addr;
                rf_data_reg <= sel_data;
            end else begin
                rf_we_reg <= 1'b0;
            end
        end
    end

    assign rf_we      = rf_we_reg;
    assign rf_addr_rd = rf_addr_reg;
    assign rf_data_rd = rf_data_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter. A small register-file model
// sits on the write port, so that committed data can be read back.
module tb_regfile_wb_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREQ = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 issue_valid;
    logic [AW-1:0]        issue_rd;
    logic                 rf_we;
    logic [AW-1:0]        rf_addr_rd;
    logic [XLEN-1:0]      rf_data_rd;
    logic [2**AW-1:0]     busy;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] rf_model [2**AW];

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rf_we       (rf_we),
        .rf_addr_rd  (rf_addr_rd),
        .rf_data_rd  (rf_data_rd),
        .busy        (busy)
    );

    // Register file write port. It ignores writes while rst is high, so a
    // write that is pending when reset hits is lost.
    always @(posedge clk) begin
        if (!rst && rf_we) begin
            rf_model[rf_addr_rd] <= rf_data_rd;
        end
    end

    function automatic logic [XLEN-1:0] rf_read(input logic [AW-1:0] a);
        return (a == '0) ? '0 : rf_model[a];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v,
                         input logic [AW-1:0] a2, input logic [AW-1:0] a1, input logic [AW-1:0] a0,
                         input logic [XLEN-1:0] d2, input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d0);
        req_valid = v;
        req_addr  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
        #1;
    endtask

    task automatic idle();
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        for (int r = 0; r < 2**AW; r++) rf_model[r] = '0;
        rst         = 1'b1;
        issue_valid = 1'b0;
        issue_rd    = '0;
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);

        // Reset state, with every source requesting.
        tick();
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_we", 64'(rf_we), 64'h0);
        check("rst_addr", 64'(rf_addr_rd), 64'h0);
        check("rst_data", 64'(rf_data_rd), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        idle();
        rst = 1'b0;
        tick();
        tick();

        // ALU writes x5 = ABCD1234.
        drive(3'b001, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'hABCD1234);
        check("alu_ready", 64'(req_ready), 64'h1);
        tick();
        check("alu_we", 64'(rf_we), 64'h1);
        check("alu_addr", 64'(rf_addr_rd), 64'd5);
        check("alu_data", 64'(rf_data_rd), 64'hABCD1234);
        idle();
        check("idle_ready", 64'(req_ready), 64'h0);
        tick();
        check("idle_we", 64'(rf_we), 64'h0);
        check("rf_x5", 64'(rf_read(5'd5)), 64'hABCD1234);

        // Fairness from pointer 0: a one-cycle reset rewinds the pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(3'b111, 5'd3, 5'd2, 5'd1, 32'h33, 32'h22, 32'h11);
        for (int c = 0; c < 6; c++) begin
            int src;
            src = c % 3;
            check($sformatf("rr_ready_%0d", c), 64'(req_ready), 64'(1 << src));
            tick();
            check($sformatf("rr_addr_%0d", c), 64'(rf_addr_rd), 64'(src + 1));
        end
        idle();
        tick();

        // LSU writes x0: it is granted, but no write reaches the register file.
        // The pointer then sits at 2.
        drive(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'hFFFFFFFF, 32'h0);
        check("x0_ready", 64'(req_ready), 64'h2);
        tick();
        check("x0_we", 64'(rf_we), 64'h0);
        check("x0_busy", 64'(busy), 64'h0);
        drive(3'b111, 5'd3, 5'd2, 5'd1, 32'h0, 32'h0, 32'h0);
        check("x0_ptr2", 64'(req_ready), 64'h4);
        idle();
        check("rf_x0", 64'(rf_read(5'd0)), 64'h0);

        // Scoreboard lifecycle for x7.
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        issue_valid = 1'b0;
        check("sb_set7", 64'(busy), 64'(32'h1 << 7));
        drive(3'b100, 5'd7, 5'd0, 5'd0, 32'h00000042, 32'h0, 32'h0);
        check("mdu_ready", 64'(req_ready), 64'h4);
        tick();
        idle();
        check("mdu_we", 64'(rf_we), 64'h1);
        check("sb_hold7", 64'(busy), 64'(32'h1 << 7));
        tick();
        check("sb_clr7", 64'(busy), 64'h0);
        check("rf_x7", 64'(rf_read(5'd7)), 64'h42);
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        tick();
        issue_valid = 1'b0;
        check("sb_rd0", 64'(busy), 64'h0);

        // Set and clear of x9 on the same edge: the set wins.
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        tick();
        issue_valid = 1'b0;
        drive(3'b001, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h99);
        check("x9_ready", 64'(req_ready), 64'h1);
        tick();
        idle();
        check("x9_we", 64'(rf_we), 64'h1);
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        tick();
        issue_valid = 1'b0;
        check("sb_setwins9", 64'(busy), 64'(32'h1 << 9));

        // Reset lands while the x4 write is pending.
        drive(3'b010, 5'd0, 5'd4, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0);
        check("x4_ready", 64'(req_ready), 64'h2);
        tick();
        check("x4_we", 64'(rf_we), 64'h1);
        rst = 1'b1;
        drive(3'b111, 5'd3, 5'd2, 5'd1, 32'h0, 32'h0, 32'h0);
        check("mid_rst_ready0", 64'(req_ready), 64'h0);
        tick();
        check("mid_rst_ready1", 64'(req_ready), 64'h0);
        check("mid_rst_we", 64'(rf_we), 64'h0);
        check("mid_rst_busy", 64'(busy), 64'h0);
        check("rf_x4", 64'(rf_read(5'd4)), 64'h0);
        rst = 1'b0;
        #1;
        check("post_rst_ptr0", 64'(req_ready), 64'h1);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Controller for the integer register file's single write port. Up to NUM_REQ writeback sources (ALU, LSU, MUL/DIV) compete for the port through a valid/ready handshake. A round-robin arbiter picks one source per cycle and drives a registered write to the register file. The block also keeps a per-register busy scoreboard: issue marks a destination busy, and the committed write clears it. Decode hazard logic reads this scoreboard.

Parameters:
XLEN, 32, data width
ADDR_WIDTH, 5, register index width
NUM_REQ, 3, number of writeback requesters (≥2)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset, synchronous active-high
req_valid  in  NUM_REQ  per-source write request
req_addr  in  NUM_REQ*ADDR_WIDTH  per-source destination index, source i in slice [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data  in  NUM_REQ*XLEN  per-source write data, same slicing
req_ready  out  NUM_REQ  grant, one-hot or zero, combinational
issue_valid  in  1  decode issued an instruction with a destination
issue_rd  in  ADDR_WIDTH  destination of issued instruction
rf_we  out  1  to register_file we
rf_addr_rd  out  ADDR_WIDTH  to register_file addr_rd
rf_data_rd  out  XLEN  to register_file data_rd
busy  out  2**ADDR_WIDTH  scoreboard, bit r = register r has a pending producer

Behaviour:
- Reset (synchronous, rst high at posedge):
  - rf_we=0, rf_addr_rd=0, rf_data_rd=0.
  - busy=0, rr_ptr=0.
  - req_ready is 0 during reset regardless of req_valid.
- Arbitration (combinational):
  - Scan sources starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all others get 0.
  - No valid request means req_ready=0.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i] at a posedge.
  - A source must hold valid, addr and data stable until it is granted.
  - The arbiter never withdraws ready within a cycle.
- Pointer:
  - On a transfer from source i, rr_ptr <= (i+1) mod NUM_REQ.
  - With no transfer, rr_ptr holds.
  - A source that keeps requesting is therefore granted at least once every NUM_REQ transfers.
- Write output:
  - One-cycle latency. On the edge of a transfer from i: rf_we<=1, rf_addr_rd<=req_addr[i], rf_data_rd<=req_data[i].
  - With no transfer: rf_we<=0, and addr/data hold their last values.
  - The register file commits at the following posedge.
- x0 writes:
  - A request with addr 0 is granted normally, so ready asserts and the pointer advances.
  - rf_we<=0 for that write, and the scoreboard is unaffected.
- Scoreboard:
  - On a posedge with issue_valid && issue_rd!=0: busy[issue_rd]<=1.
  - On a posedge with rf_we=1 (the commit edge): busy[rf_addr_rd]<=0.
  - Busy therefore drops the cycle after rf_we is seen, and readers never see busy=0 before the data is in the register file.
  - Set and clear on the same index in the same cycle: set wins, because a new producer was issued.
  - busy[0] is constant 0.
- Reset mid-operation:
  - A pending rf_we is dropped and the write is lost.
  - All busy bits are cleared.
  - Requesters must re-present their requests after reset.
- Widths: all index comparisons are ADDR_WIDTH bits. rr_ptr is $clog2(NUM_REQ) bits, and the wrap is explicit because NUM_REQ need not be a power of two.

Decomposition:
- Shared core package: XLEN, ADDR_WIDTH, NUM_REGS=2**ADDR_WIDTH, and named source indices (WB_SRC_ALU=0, WB_SRC_LSU=1, WB_SRC_MDU=2).
- One sub-module, rr_arbiter (parameter N). It contains the request vector, the pointer state and the one-hot grant, and is reusable elsewhere.
- The scoreboard and the output register stay in the top module.

Test Plan:
- Reset, then single source: after 2 idle cycles, ALU requests x5=ABCD1234 → ready[0]=1 that cycle, rf_we=1/addr=5/data=ABCD1234 the next cycle; register_file read of x5 returns ABCD1234.
- Round-robin fairness: all three sources hold valid for 6 cycles with x1/x2/x3 → grant order 0,1,2,0,1,2; a source that keeps valid high is never skipped twice.
- x0 write: LSU writes x0=FFFFFFFF → ready asserted, rf_we stays 0, rr_ptr advances to 2; x0 still reads 0.
- Scoreboard lifecycle: issue rd=7 → busy[7]=1 next cycle; MDU writes x7=00000042 → busy[7]=0 one cycle after rf_we; issue rd=0 → busy unchanged.
- Same-cycle set/clear: rf_we commits x9 while issue_rd=9 → busy[9] remains 1.
- Reset mid-operation: assert rst in the cycle rf_we=1 for x4=DEADBEEF → no commit (x4 reads 0), busy=0, rr_ptr=0, req_ready=0 throughout reset.
